// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - serial binary-to-BCD converter driving a 3-digit multiplexed seven-segment display
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero hundreds/tens digits).
module count_bcd_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  count,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cap;
    logic [7:0]  sr;
    logic [11:0] acc;
    logic [11:0] acc_adj;
    logic [2:0]  bit_cnt;
    logic        load_en;
    logic        shift_en;
    logic        done_en;

    logic [15:0] presc;
    logic [1:0]  digit_sel;
    logic [3:0]  nibble;
    logic        blank;
    logic [2:0]  an_next;
    logic [6:0]  seg_next;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != cap) state_next = SHIFT;
            SHIFT:   if (bit_cnt == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_en  = (state == IDLE) && (count != cap);
        shift_en = (state == SHIFT);
        done_en  = (state == DONE);
    end

    // Double-dabble: correct each BCD nibble before the shift that doubles it.
    always_comb begin
        acc_adj = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap       <= 8'd0;
            sr        <= 8'd0;
            acc       <= 12'd0;
            bit_cnt   <= 3'd0;
            bcd       <= 12'h000;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (load_en) begin
                cap     <= count;
                sr      <= count;
                acc     <= 12'd0;
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                {acc, sr} <= {acc_adj[10:0], sr, 1'b0};
                bit_cnt   <= bit_cnt + 3'd1;
            end else if (done_en) begin
                bcd       <= acc;
                bcd_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= 16'd0;
            digit_sel <= 2'd0;
        end else if (presc == PRESC_MAX) begin
            presc     <= 16'd0;
            digit_sel <= (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    always_comb begin
        nibble  = bcd[3:0];
        an_next = 3'b110;
        blank   = 1'b0;
        case (digit_sel)
            2'd1: begin
                nibble  = bcd[7:4];
                an_next = 3'b101;
            end
            2'd2: begin
                nibble  = bcd[11:8];
                an_next = 3'b011;
            end
            default: ;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((digit_sel == 2'd2) && (bcd[11:8] == 4'd0)) ||
                ((digit_sel == 2'd1) && (bcd[11:4] == 8'd0));
`endif
        seg_next = blank ? 7'b1111111 : seg_decode(nibble);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 3'b110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_count_bcd_display.sv
// tb/tb_count_bcd_display.sv - scoreboard bench for count_bcd_display
module tb_count_bcd_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  count;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [2:0]  an;
    logic [6:0]  seg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;
    logic [7:0]  cur;
    logic [11:0] exp_bcd_q[$];
    int          exp_cyc_q[$];

    count_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [6:0] slot_seg(input logic [2:0] a, input logic [6:0] s_ones,
                                            input logic [6:0] s_tens, input logic [6:0] s_hund);
        case (a)
            3'b110:  return s_ones;
            3'b101:  return s_tens;
            3'b011:  return s_hund;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic logic [2:0] next_an(input logic [2:0] a);
        case (a)
            3'b110:  return 3'b101;
            3'b101:  return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    // Every bcd_valid pulse must match the oldest expected conversion, at its expected cycle.
    always @(negedge clk) begin
        if (bcd_valid) begin
            pulses++;
            if (exp_bcd_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                check("bcd_value", bcd, exp_bcd_q.pop_front());
                check("latency", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    task automatic drive_count(input logic [7:0] v);
        @(negedge clk);
        if (v != cur) begin
            exp_bcd_q.push_back(to_bcd(v));
            exp_cyc_q.push_back(cyc + 10);
        end
        count = v;
        cur   = v;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_bcd_q.size() != 0; i++) @(negedge clk);
        if (exp_bcd_q.size() != 0) begin
            check("drain_timeout", exp_bcd_q.size(), 0);
            exp_bcd_q.delete();
            exp_cyc_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic scan_check(input string tag, input logic [6:0] s_ones,
                              input logic [6:0] s_tens, input logic [6:0] s_hund);
        logic [2:0] prev_an;
        int         run;
        bit         first;
        @(negedge clk);
        prev_an = an;
        run     = 1;
        first   = 1'b1;
        check({tag, "_seg"}, seg, slot_seg(an, s_ones, s_tens, s_hund));
        repeat (30) begin
            @(negedge clk);
            if (an != prev_an) begin
                if (!first) check({tag, "_hold"}, run, SCAN_DIV);
                check({tag, "_order"}, an, next_an(prev_an));
                first   = 1'b0;
                prev_an = an;
                run     = 1;
            end else begin
                run++;
            end
            check({tag, "_seg"}, seg, slot_seg(an, s_ones, s_tens, s_hund));
        end
    endtask

    initial begin
        int p0;
        int m;
        logic [7:0] vals[8] = '{8'd1, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd254, 8'd0};

        reset = 1'b1;
        count = 8'd0;
        cur   = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_bcd", bcd, 12'h000);
        check("rst_valid", bcd_valid, 1'b0);
        check("rst_an", an, 3'b110);
        check("rst_seg", seg, 7'b1000000);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("zero_start_pulses", pulses, 0);

        drive_count(8'd255);
        drain(30);

        // Second value arrives mid-conversion and is picked up on the return to IDLE.
        @(negedge clk);
        count = 8'd100;
        exp_bcd_q.push_back(12'h100);
        exp_cyc_q.push_back(cyc + 10);
        repeat (3) @(negedge clk);
        count = 8'd101;
        exp_bcd_q.push_back(12'h101);
        exp_cyc_q.push_back(cyc + 17);
        cur = 8'd101;
        drain(40);

        foreach (vals[i]) begin
            drive_count(vals[i]);
            drain(30);
        end
        repeat (4) begin
            drive_count(8'($urandom_range(0, 255)));
            drain(30);
        end

        drive_count(8'd123);
        drain(30);
        scan_check("scan", 7'b0110000, 7'b0100100, 7'b1111001);

        drive_count(8'd7);
        drain(30);
`ifdef LEADING_ZERO_BLANK_EN
        scan_check("blank", 7'b1111000, 7'b1111111, 7'b1111111);
`else
        scan_check("blank", 7'b1111000, 7'b1000000, 7'b1000000);
`endif

        p0 = pulses;
        repeat (50) @(negedge clk);
        check("idle_pulses", pulses - p0, 0);
        check("idle_bcd", bcd, to_bcd(cur));

        // Reset lands in the 4th SHIFT cycle of a 200 conversion.
        @(negedge clk);
        count = 8'd200;
        m = cyc;
        while (cyc < m + 4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_bcd", bcd, 12'h000);
        check("midrst_valid", bcd_valid, 1'b0);
        check("midrst_an", an, 3'b110);
        check("midrst_seg", seg, 7'b1000000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_bcd_q.push_back(12'h200);
        exp_cyc_q.push_back(cyc + 10);
        cur = 8'd200;
        drain(30);
        check("final_bcd", bcd, 12'h200);
        check("queue_empty", exp_bcd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
